// File: rtl/spi_master_seq_ctrl.sv
// rtl/spi_master_seq_ctrl.sv - SPI master transfer sequencer with CPOL/CPHA, 1/2/4 lanes, shared chip selects
module spi_master_seq_ctrl #(
    parameter int NO_OF_SLAVES = 1,
    parameter int DATA_WIDTH   = 8,
    parameter int DIV_WIDTH    = 8,
    localparam int SEL_W       = (NO_OF_SLAVES > 1) ? $clog2(NO_OF_SLAVES) : 1
) (
    input  logic                    pclk,
    input  logic                    areset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [SEL_W-1:0]        req_slave_sel,
    input  logic [1:0]              req_mode,
    input  logic                    req_dir,
    input  logic [2:0]              req_lanes,
    input  logic [DIV_WIDTH-1:0]    req_div,
    input  logic [DATA_WIDTH-1:0]   req_tx_data,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rx_data,
    output logic                    rsp_err,
    output logic                    busy,
    output logic                    sclk,
    output logic [NO_OF_SLAVES-1:0] cs_n,
    output logic [3:0]              mosi,
    output logic [3:0]              mosi_oe,
    input  logic [3:0]              miso
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] XFER  = 3'd2;
    localparam logic [2:0] HOLD  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;
    localparam int EW = $clog2(2 * DATA_WIDTH + 1);

    logic [2:0]              state, lanes_q, lanes_n;
    logic [DIV_WIDTH-1:0]    div_q, div_n, cnt;
    logic [EW-1:0]           ecnt, last_e;
    logic                    cpol_q, cpha_q, dir_q, err_q;
    logic [DATA_WIDTH-1:0]   tx_sh, rx_sh;
    logic [NO_OF_SLAVES-1:0] sel_mask;
    logic                    sel_err, sample_edge;

    function automatic logic [3:0] lane_mask(input logic [2:0] l);
        case (l)
            3'd4:    lane_mask = 4'hF;
            3'd2:    lane_mask = 4'h3;
            default: lane_mask = 4'h1;
        endcase
    endfunction

    // MSB-first pulls beats from the top of the shift register, LSB-first from the bottom
    function automatic logic [3:0] beat_of(input logic [DATA_WIDTH-1:0] sh, input logic dir,
                                           input logic [2:0] l);
        if (dir)
            beat_of = 4'(sh >> (DATA_WIDTH - int'(l))) & lane_mask(l);
        else
            beat_of = 4'(sh) & lane_mask(l);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_tx(input logic [DATA_WIDTH-1:0] sh,
                                                        input logic dir, input logic [2:0] l);
        shift_tx = dir ? (sh << l) : (sh >> l);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_rx(input logic [DATA_WIDTH-1:0] sh,
                                                        input logic dir, input logic [2:0] l,
                                                        input logic [3:0] m);
        logic [DATA_WIDTH-1:0] in_bits;
        in_bits = DATA_WIDTH'(m & lane_mask(l));
        if (dir)
            shift_rx = (sh << l) | in_bits;
        else
            shift_rx = (sh >> l) | (in_bits << (DATA_WIDTH - int'(l)));
    endfunction

    always_comb begin
        lanes_n = (req_lanes == 3'd2 || req_lanes == 3'd4) ? req_lanes : 3'd1;
        div_n   = (req_div == '0) ? DIV_WIDTH'(1) : req_div;
        sel_err = (32'(req_slave_sel) >= 32'(NO_OF_SLAVES));
        for (int i = 0; i < NO_OF_SLAVES; i++)
            sel_mask[i] = (32'(req_slave_sel) == 32'(i));
        case (lanes_q)
            3'd4:    last_e = EW'(DATA_WIDTH / 2 - 1);
            3'd2:    last_e = EW'(DATA_WIDTH - 1);
            default: last_e = EW'(2 * DATA_WIDTH - 1);
        endcase
        // even edge count means the next toggle is a leading edge
        sample_edge = ~ecnt[0] ^ cpha_q;
    end

    assign req_ready = (state == IDLE) & ~areset;
    assign busy      = (state != IDLE);

    always_ff @(posedge pclk) begin
        if (areset) begin
            state       <= IDLE;
            lanes_q     <= 3'd1;
            div_q       <= DIV_WIDTH'(1);
            cnt         <= '0;
            ecnt        <= '0;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            dir_q       <= 1'b0;
            err_q       <= 1'b0;
            tx_sh       <= '0;
            rx_sh       <= '0;
            rsp_valid   <= 1'b0;
            rsp_rx_data <= '0;
            rsp_err     <= 1'b0;
            sclk        <= 1'b0;
            cs_n        <= '1;
            mosi        <= 4'h0;
            mosi_oe     <= 4'h0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    state   <= SETUP;
                    lanes_q <= lanes_n;
                    div_q   <= div_n;
                    cnt     <= div_n - DIV_WIDTH'(1);
                    ecnt    <= '0;
                    cpol_q  <= req_mode[1];
                    cpha_q  <= req_mode[0];
                    dir_q   <= req_dir;
                    err_q   <= sel_err;
                    rx_sh   <= '0;
                    sclk    <= req_mode[1];
                    cs_n    <= ~sel_mask;
                    mosi_oe <= lane_mask(lanes_n);
                    if (!req_mode[0]) begin
                        mosi  <= beat_of(req_tx_data, req_dir, lanes_n);
                        tx_sh <= shift_tx(req_tx_data, req_dir, lanes_n);
                    end else begin
                        mosi  <= 4'h0;
                        tx_sh <= req_tx_data;
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        state <= XFER;
                        cnt   <= div_q - DIV_WIDTH'(1);
                    end else begin
                        cnt <= cnt - DIV_WIDTH'(1);
                    end
                end
                XFER: begin
                    if (cnt == '0) begin
                        cnt  <= div_q - DIV_WIDTH'(1);
                        sclk <= ~sclk;
                        ecnt <= ecnt + EW'(1);
                        if (sample_edge) begin
                            rx_sh <= shift_rx(rx_sh, dir_q, lanes_q, miso);
                        end else if (ecnt != last_e) begin
                            mosi  <= beat_of(tx_sh, dir_q, lanes_q);
                            tx_sh <= shift_tx(tx_sh, dir_q, lanes_q);
                        end
                        if (ecnt == last_e)
                            state <= HOLD;
                    end else begin
                        cnt <= cnt - DIV_WIDTH'(1);
                    end
                end
                HOLD: begin
                    sclk <= cpol_q;
                    if (cnt == '0) begin
                        state       <= DONE;
                        cs_n        <= '1;
                        mosi        <= 4'h0;
                        mosi_oe     <= 4'h0;
                        rsp_valid   <= 1'b1;
                        rsp_rx_data <= rx_sh;
                        rsp_err     <= err_q;
                    end else begin
                        cnt <= cnt - DIV_WIDTH'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
